// File: rtl/dmem_input_reader_pkg.sv
// Shared definitions for the data-memory input reader peripheral.
// Contents:
//   reg_sel_e  - word offset of each register inside the 4-word window
//   ID_VALUE   - constant returned by the ID register ("BIN1")
//   COUNT_W    - width of the press counter
//   popcount() - number of set bits in an 8-bit vector
package dmem_input_reader_pkg;

  typedef enum logic [1:0] {
    OFF_STATUS = 2'd0,
    OFF_EVENT  = 2'd1,
    OFF_COUNT  = 2'd2,
    OFF_ID     = 2'd3
  } reg_sel_e;

  localparam logic [31:0] ID_VALUE = 32'h4249_4E31;
  localparam int          COUNT_W  = 16;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dmem_input_reader_if.sv
// CPU data-memory bus as seen by a memory-mapped peripheral.
// Signals:
//   MEM_ADDR_BUS    - word address driven by the CPU
//   MEM_READ_WRN    - 1 = read, 0 = write
//   MEM_WR_DATA_BUS - write data driven by the CPU
//   RD_DATA_BUS     - read data returned by the peripheral
//   HIT             - peripheral claims the current address
// Modports: master = CPU side, slave = peripheral side.
interface dmem_input_reader_if;
  logic [31:0] MEM_ADDR_BUS;
  logic        MEM_READ_WRN;
  logic [31:0] MEM_WR_DATA_BUS;
  logic [31:0] RD_DATA_BUS;
  logic        HIT;

  modport master (
    output MEM_ADDR_BUS, MEM_READ_WRN, MEM_WR_DATA_BUS,
    input  RD_DATA_BUS, HIT
  );

  modport slave (
    input  MEM_ADDR_BUS, MEM_READ_WRN, MEM_WR_DATA_BUS,
    output RD_DATA_BUS, HIT
  );
endinterface

// File: rtl/dmem_input_reader_debouncer.sv
// input_debouncer: one raw asynchronous input -> clean debounced level.
// A 2-flop synchroniser feeds a counter that runs while the synced value
// disagrees with the current level; DEBOUNCE_CYCLES consecutive
// disagreeing cycles are needed before the level flips.
// Ports:
//   CK_REF  - system clock
//   RST_N   - asynchronous active-low reset
//   raw_in  - raw asynchronous input
//   level   - debounced level
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CK_REF,
  input  logic RST_N,
  input  logic raw_in,
  output logic level
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic             level_p2;

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      cnt_p2   <= '0;
      level_p2 <= 1'b0;
    end else begin
      // synchroniser stages
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
      // debounce stage: any agreement restarts the stability window
      if (sync_p1 == level_p2) begin
        cnt_p2 <= '0;
      end else if (cnt_p2 == CNT_MAX) begin
        level_p2 <= sync_p1;
        cnt_p2   <= '0;
      end else begin
        cnt_p2 <= cnt_p2 + 1'b1;
      end
    end
  end

  assign level = level_p2;

endmodule

// File: rtl/dmem_input_reader.sv
// dmem_input_reader: read-side memory-mapped peripheral for buttons and
// switches. Debounces every input, latches button-press events (W1C) and
// counts presses. Four word registers from BASE_ADDR: STATUS, EVENT,
// COUNT, ID.
// Ports:
//   CK_REF        - system clock
//   RST_N         - asynchronous active-low reset
//   BTN_IN        - raw buttons, active-high
//   SW_IN         - raw switches
//   bus           - CPU data-memory bus (slave side)
//   EVENT_PENDING - registered OR of all EVENT bits
module dmem_input_reader
  import dmem_input_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0004,
  parameter int          N_BTN           = 4,
  parameter int          N_SW            = 4,
  parameter int          DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 CK_REF,
  input  logic                 RST_N,
  input  logic [N_BTN-1:0]     BTN_IN,
  input  logic [N_SW-1:0]      SW_IN,
  dmem_input_reader_if.slave   bus,
  output logic                 EVENT_PENDING
);

  logic [N_BTN-1:0]   btn_db;
  logic [N_SW-1:0]    sw_db;
  logic [N_BTN-1:0]   btn_db_prev;
  logic [N_BTN-1:0]   btn_rise;
  logic [N_BTN-1:0]   event_q;
  logic [COUNT_W-1:0] count_q;
  logic               pending_q;
  logic [31:0]        addr_off;
  logic               hit;
  reg_sel_e           sel;
  logic               wr_strobe;
  logic               unused_wdata;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CK_REF (CK_REF),
      .RST_N  (RST_N),
      .raw_in (BTN_IN[i]),
      .level  (btn_db[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CK_REF (CK_REF),
      .RST_N  (RST_N),
      .raw_in (SW_IN[i]),
      .level  (sw_db[i])
    );
  end

  // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
  assign addr_off  = bus.MEM_ADDR_BUS - BASE_ADDR;
  assign hit       = (addr_off < 32'd4);
  assign sel       = reg_sel_e'(addr_off[1:0]);
  assign wr_strobe = hit && !bus.MEM_READ_WRN;
  assign btn_rise  = btn_db & ~btn_db_prev;
  assign unused_wdata = ^bus.MEM_WR_DATA_BUS;

  // event/count stage: a rise sets its bit even when the same write clears it,
  // and a COUNT write takes priority over presses in that cycle
  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      btn_db_prev <= '0;
      event_q     <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
    end else begin
      btn_db_prev <= btn_db;
      pending_q   <= |event_q;
      if (wr_strobe && sel == OFF_EVENT) begin
        event_q <= (event_q & ~bus.MEM_WR_DATA_BUS[N_BTN-1:0]) | btn_rise;
      end else begin
        event_q <= event_q | btn_rise;
      end
      if (wr_strobe && sel == OFF_COUNT) begin
        count_q <= bus.MEM_WR_DATA_BUS[COUNT_W-1:0];
      end else begin
        count_q <= count_q + COUNT_W'(popcount(8'(btn_rise)));
      end
    end
  end

  always_comb begin
    bus.RD_DATA_BUS = 32'd0;
    if (hit) begin
      case (sel)
        OFF_STATUS: begin
          bus.RD_DATA_BUS[N_BTN-1:0] = btn_db;
          bus.RD_DATA_BUS[16 +: N_SW] = sw_db;
        end
        OFF_EVENT: bus.RD_DATA_BUS[N_BTN-1:0]   = event_q;
        OFF_COUNT: bus.RD_DATA_BUS[COUNT_W-1:0] = count_q;
        default:   bus.RD_DATA_BUS              = ID_VALUE;
      endcase
    end
  end

  assign bus.HIT       = hit;
  assign EVENT_PENDING = pending_q;

endmodule

// File: tb/tb_dmem_input_reader.sv
module tb_dmem_input_reader;
  import dmem_input_reader_pkg::*;

  localparam int D = 4;

  logic       CK_REF = 1'b0;
  logic       RST_N;
  logic [3:0] BTN_IN;
  logic [3:0] SW_IN;
  logic       EVENT_PENDING;

  dmem_input_reader_if bus();

  dmem_input_reader #(
    .BASE_ADDR       (32'h0000_0004),
    .N_BTN           (4),
    .N_SW            (4),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .CK_REF        (CK_REF),
    .RST_N         (RST_N),
    .BTN_IN        (BTN_IN),
    .SW_IN         (SW_IN),
    .bus           (bus),
    .EVENT_PENDING (EVENT_PENDING)
  );

  always #20 CK_REF = ~CK_REF;

  int total = 0;
  int bad   = 0;

  // Reference model: debounced level flips when the last D synchronised
  // samples all disagree with it; synchronised sample at edge n is the raw
  // value captured at edge n-2 (zero for the first two edges after reset).
  logic [7:0]  log_q[$];
  logic [3:0]  m_btn, m_sw, m_event, m_rise;
  logic [15:0] m_count;
  logic        m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    log_q.delete();
    m_btn = 0; m_sw = 0; m_event = 0; m_rise = 0; m_count = 0; m_pend = 0;
  endtask

  function automatic logic [7:0] seen(input int n);
    if (n < 3) return 8'd0;
    return log_q[n-3];
  endfunction

  task automatic model_edge(input logic [7:0] raw, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [3:0] old_ev;
    logic [7:0] lv_old, lv_new, s;
    logic       flip;
    int         n;
    old_ev = m_event;
    lv_old = {m_sw, m_btn};
    log_q.push_back(raw);
    n = log_q.size();
    if (wr && addr == 32'd5) m_event = (m_event & ~wdata[3:0]) | m_rise;
    else                     m_event = m_event | m_rise;
    if (wr && addr == 32'd6) m_count = wdata[15:0];
    else                     m_count = m_count + 16'($countones(m_rise));
    m_pend = |old_ev;
    lv_new = lv_old;
    for (int b = 0; b < 8; b++) begin
      flip = 1'b1;
      for (int k = 0; k < D; k++) begin
        s = seen(n - k);
        if (s[b] == lv_old[b]) flip = 1'b0;
      end
      if (flip) lv_new[b] = ~lv_old[b];
    end
    m_rise = lv_new[3:0] & ~lv_old[3:0];
    {m_sw, m_btn} = lv_new;
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    case (a)
      32'd4:   return {12'd0, m_sw, 12'd0, m_btn};
      32'd5:   return {28'd0, m_event};
      32'd6:   return {16'd0, m_count};
      32'd7:   return 32'h4249_4E31;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all();
    for (int a = 3; a <= 7; a++) begin
      bus.MEM_ADDR_BUS = a;
      #1;
      chk($sformatf("rd@%0d", a), bus.RD_DATA_BUS, exp_rd(a));
      chk($sformatf("hit@%0d", a), {31'd0, bus.HIT}, {31'd0, (a >= 4)});
    end
    chk("pending", {31'd0, EVENT_PENDING}, {31'd0, m_pend});
  endtask

  task automatic cycle();
    @(posedge CK_REF);
    if (RST_N) model_edge({SW_IN, BTN_IN}, !bus.MEM_READ_WRN, bus.MEM_ADDR_BUS, bus.MEM_WR_DATA_BUS);
    @(negedge CK_REF);
    bus.MEM_READ_WRN = 1'b1;
    check_all();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.MEM_ADDR_BUS    = a;
    bus.MEM_WR_DATA_BUS = d;
    bus.MEM_READ_WRN    = 1'b0;
    cycle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.MEM_ADDR_BUS = a;
    #1;
    d = bus.RD_DATA_BUS;
  endtask

  initial begin
    logic [31:0] v;
    RST_N = 1'b0;
    BTN_IN = 4'd0;
    SW_IN  = 4'd0;
    bus.MEM_ADDR_BUS = 32'd0;
    bus.MEM_READ_WRN = 1'b1;
    bus.MEM_WR_DATA_BUS = 32'd0;
    model_reset();
    repeat (2) @(negedge CK_REF);
    check_all();
    RST_N = 1'b1;

    // 1. idle register map
    cycle();
    rd(4, v); chk("t1_status", v, 32'd0);
    rd(5, v); chk("t1_event", v, 32'd0);
    rd(6, v); chk("t1_count", v, 32'd0);
    rd(7, v); chk("t1_id", v, 32'h4249_4E31);
    rd(3, v); chk("t1_miss_rd", v, 32'd0);
    chk("t1_miss_hit", {31'd0, bus.HIT}, 32'd0);

    // 2. single press latency
    BTN_IN[2] = 1'b1;
    repeat (5) cycle();
    rd(4, v); chk("t2_status_early", v, 32'd0);
    cycle();
    rd(4, v); chk("t2_status", v, 32'h4);
    cycle();
    rd(5, v); chk("t2_event", v, 32'h4);
    rd(6, v); chk("t2_count", v, 32'h1);
    chk("t2_pend_early", {31'd0, EVENT_PENDING}, 32'd0);
    cycle();
    chk("t2_pend", {31'd0, EVENT_PENDING}, 32'd1);

    // 3. short glitches on BTN0
    for (int r = 0; r < 3; r++) begin
      for (int len = 1; len <= 3; len++) begin
        BTN_IN[0] = 1'b1;
        repeat (len) cycle();
        BTN_IN[0] = 1'b0;
        repeat (2) cycle();
      end
    end
    repeat (6) cycle();
    rd(4, v); chk("t3_status", v, 32'h4);
    rd(5, v); chk("t3_event", v, 32'h4);
    rd(6, v); chk("t3_count", v, 32'h1);

    // 4. W1C coincident with rises
    BTN_IN[1] = 1'b1;
    repeat (6) cycle();
    wr(5, 32'h4);
    rd(5, v); chk("t4_event_a", v, 32'h2);
    BTN_IN[1] = 1'b0;
    repeat (8) cycle();
    BTN_IN[1] = 1'b1;
    repeat (6) cycle();
    wr(5, 32'h2);
    rd(5, v); chk("t4_event_b", v, 32'h2);
    rd(6, v); chk("t4_count", v, 32'h3);

    // 5. counter wrap and double press
    wr(6, 32'h0000_FFFF);
    rd(6, v); chk("t5_load", v, 32'h0000_FFFF);
    BTN_IN[0] = 1'b1;
    repeat (7) cycle();
    rd(6, v); chk("t5_wrap", v, 32'h0);
    BTN_IN[0] = 1'b0;
    repeat (8) cycle();
    BTN_IN[0] = 1'b1;
    BTN_IN[3] = 1'b1;
    repeat (7) cycle();
    rd(6, v); chk("t5_double", v, 32'h2);

    // 6. reset mid-debounce
    SW_IN[0] = 1'b1;
    repeat (4) cycle();
    RST_N = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) cycle();
    RST_N = 1'b1;
    repeat (5) cycle();
    rd(4, v); chk("t6_status_early", v, 32'd0);
    cycle();
    rd(4, v); chk("t6_status", v, 32'h0001_000F);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) BTN_IN = BTN_IN ^ 4'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) SW_IN  = SW_IN ^ 4'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) wr($urandom_range(3, 8), $urandom);
      else                           cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
